// File: rtl/reg_check_pkg.sv
// Shared types and helpers for the register self-check monitor.
// Holds the FSM state encoding and the index-width helper used for port sizing.
package reg_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Width able to index n items; never below 1 so single-entry builds stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_check_table.sv
// Expected-value table: NUM_CHECKS entries of {valid, addr, data}.
// One write port, one combinational read port; only the valid bits are reset.
module reg_check_table
   import reg_check_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_CHECKS = 8,
   localparam int IDX_W     = idx_w(NUM_CHECKS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic              wvalid,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic              rvalid,
   output logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [NUM_CHECKS-1:0] valid_q;
   logic [ADDR_W-1:0]     addr_q [NUM_CHECKS];
   logic [DATA_W-1:0]     data_q [NUM_CHECKS];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[widx] <= wvalid;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         addr_q[widx] <= waddr;
         data_q[widx] <= wdata;
      end
   end

   assign rvalid = valid_q[ridx];
   assign raddr  = addr_q[ridx];
   assign rdata  = data_q[ridx];

endmodule

// File: rtl/reg_check_monitor.sv
// Cycle-checkpoint register self-check: runs to a programmed cycle, freezes the
// core, scans the expected table against the register file and reports results.
module reg_check_monitor
   import reg_check_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_CHECKS = 8,
   parameter int CYCLE_W    = 32,
   localparam int IDX_W     = idx_w(NUM_CHECKS),
   localparam int FAIL_W    = idx_w(NUM_CHECKS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CYCLE_W-1:0] check_cycle,
   input  logic               tbl_we,
   input  logic [IDX_W-1:0]   tbl_idx,
   input  logic               tbl_valid,
   input  logic [ADDR_W-1:0]  tbl_addr,
   input  logic [DATA_W-1:0]  tbl_data,
   output logic [ADDR_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               freeze,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic [FAIL_W-1:0]  fail_count,
   output logic [IDX_W-1:0]   first_fail_idx,
   output logic [DATA_W-1:0]  first_fail_data
);

   state_e             state_q, state_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic [CYCLE_W-1:0] chk_q, chk_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FAIL_W-1:0]  fail_q, fail_d;
   logic [IDX_W-1:0]   ffidx_q, ffidx_d;
   logic [DATA_W-1:0]  ffdata_q, ffdata_d;

   logic               ent_valid;
   logic [ADDR_W-1:0]  ent_addr;
   logic [DATA_W-1:0]  ent_data;
   logic               idle_or_done;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

   reg_check_table #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .NUM_CHECKS (NUM_CHECKS)
   ) u_table (
      .clk    (clk),
      .rst    (rst),
      .we     (tbl_we && idle_or_done),
      .widx   (tbl_idx),
      .wvalid (tbl_valid),
      .waddr  (tbl_addr),
      .wdata  (tbl_data),
      .ridx   (idx_q),
      .rvalid (ent_valid),
      .raddr  (ent_addr),
      .rdata  (ent_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cycle_q  <= '0;
         chk_q    <= '0;
         idx_q    <= '0;
         fail_q   <= '0;
         ffidx_q  <= '0;
         ffdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         chk_q    <= chk_d;
         idx_q    <= idx_d;
         fail_q   <= fail_d;
         ffidx_q  <= ffidx_d;
         ffdata_q <= ffdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cycle_d  = cycle_q;
      chk_d    = chk_q;
      idx_d    = idx_q;
      fail_d   = fail_q;
      ffidx_d  = ffidx_q;
      ffdata_d = ffdata_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               chk_d    = check_cycle;
               cycle_d  = CYCLE_W'(1);
               idx_d    = '0;
               fail_d   = '0;
               ffidx_d  = '0;
               ffdata_d = '0;
            end
         end
         ST_RUN: begin
            // Checkpoints of 0 and 1 both enter SCAN on the first edge after start.
            if ((cycle_q == chk_q) || (chk_q <= CYCLE_W'(1))) begin
               state_d = ST_SCAN;
            end else begin
               cycle_d = cycle_q + CYCLE_W'(1);
            end
         end
         ST_SCAN: begin
            if (ent_valid && (rf_rdata != ent_data)) begin
               fail_d = fail_q + FAIL_W'(1);
               if (fail_q == '0) begin
                  ffidx_d  = idx_q;
                  ffdata_d = rf_rdata;
               end
            end
            if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rf_raddr        = (state_q == ST_SCAN) ? ent_addr : '0;
   assign freeze          = (state_q == ST_SCAN);
   assign busy            = (state_q == ST_RUN) || (state_q == ST_SCAN);
   assign done            = (state_q == ST_DONE);
   assign pass            = done && (fail_q == '0);
   assign cycle_count     = cycle_q;
   assign fail_count      = fail_q;
   assign first_fail_idx  = ffidx_q;
   assign first_fail_data = ffdata_q;

endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench for reg_check_monitor: table of full check runs against a
// register-file model, plus hand sequences for reset mid-scan and busy-time inputs.
module tb_reg_check_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] check_cycle;
   logic        tbl_we;
   logic [2:0]  tbl_idx;
   logic        tbl_valid;
   logic [4:0]  tbl_addr;
   logic [31:0] tbl_data;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        freeze, busy, done, pass;
   logic [31:0] cycle_count;
   logic [3:0]  fail_count;
   logic [2:0]  first_fail_idx;
   logic [31:0] first_fail_data;

   logic [31:0] rf [32];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign rf_rdata = rf[rf_raddr];

   reg_check_monitor dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .check_cycle     (check_cycle),
      .tbl_we          (tbl_we),
      .tbl_idx         (tbl_idx),
      .tbl_valid       (tbl_valid),
      .tbl_addr        (tbl_addr),
      .tbl_data        (tbl_data),
      .rf_raddr        (rf_raddr),
      .rf_rdata        (rf_rdata),
      .freeze          (freeze),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .cycle_count     (cycle_count),
      .fail_count      (fail_count),
      .first_fail_idx  (first_fail_idx),
      .first_fail_data (first_fail_data)
   );

   typedef struct {
      logic [31:0] c;
      logic [31:0] r20, r21, r23;
      logic        exp_pass;
      int          exp_fc;
      int          exp_ffidx;
      logic [31:0] exp_ffdata;
      int          exp_scan;
      int          exp_done;
      logic [31:0] exp_cyc;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   task automatic write_entry(input int idx, input logic v, input logic [4:0] a, input logic [31:0] d);
      tbl_idx   = 3'(idx);
      tbl_valid = v;
      tbl_addr  = a;
      tbl_data  = d;
      tbl_we    = 1'b1;
      tick();
      tbl_we    = 1'b0;
   endtask

   task automatic load_table();
      write_entry(0, 1'b1, 5'd19, 32'd15);
      write_entry(1, 1'b1, 5'd20, 32'd10);
      write_entry(2, 1'b1, 5'd21, 32'd3);
      write_entry(3, 1'b1, 5'd22, 32'd2);
      write_entry(4, 1'b1, 5'd23, 32'd10);
      write_entry(5, 1'b1, 5'd24, 32'd11);
      write_entry(6, 1'b0, 5'd25, 32'd1234);
      write_entry(7, 1'b0, 5'd26, 32'd5678);
   endtask

   task automatic rf_default();
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rf[19] = 32'd15; rf[20] = 32'd10; rf[21] = 32'd3;
      rf[22] = 32'd2;  rf[23] = 32'd10; rf[24] = 32'd11;
   endtask

   task automatic run_check(input string tag, input logic [31:0] c,
                            output int scan_n, output int done_n, output int frz);
      scan_n = -1;
      done_n = -1;
      frz    = 0;
      check_cycle = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      check({tag, "_cyc_after_start"}, 64'(cycle_count), 64'd1);
      for (int n = 1; n <= 400; n++) begin
         tick();
         if (freeze) begin
            frz++;
            if (scan_n < 0) scan_n = n;
         end
         if (done) begin
            done_n = n;
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rf_raddr"}, 64'(rf_raddr), 64'd0);
      check({tag, "_freeze"}, 64'(freeze), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_pass"}, 64'(pass), 64'd0);
      check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
      check({tag, "_fail_count"}, 64'(fail_count), 64'd0);
      check({tag, "_ff_idx"}, 64'(first_fail_idx), 64'd0);
      check({tag, "_ff_data"}, 64'(first_fail_data), 64'd0);
   endtask

   initial begin
      int scan_n, done_n, frz, n_seen;
      string t;

      // c, r20, r21, r23, pass, fc, ffidx, ffdata, scan edge, done edge, held cycle_count
      vecs[0] = '{32'd12, 32'd10, 32'd3, 32'd10, 1'b1, 0, 0, 32'd0,  12, 20, 32'd12};
      vecs[1] = '{32'd12, 32'd10, 32'd7, 32'd10, 1'b0, 1, 2, 32'd7,  12, 20, 32'd12};
      vecs[2] = '{32'd12, 32'd99, 32'd3, 32'd55, 1'b0, 2, 1, 32'd99, 12, 20, 32'd12};
      vecs[3] = '{32'd0,  32'd10, 32'd3, 32'd10, 1'b1, 0, 0, 32'd0,  1,  9,  32'd1};
      vecs[4] = '{32'd1,  32'd10, 32'd3, 32'd10, 1'b1, 0, 0, 32'd0,  1,  9,  32'd1};

      rst = 1'b1; start = 1'b0; check_cycle = '0;
      tbl_we = 1'b0; tbl_idx = '0; tbl_valid = 1'b0; tbl_addr = '0; tbl_data = '0;
      rf_default();
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      load_table();

      for (int i = 0; i < 5; i++) begin
         rf_default();
         rf[20] = vecs[i].r20;
         rf[21] = vecs[i].r21;
         rf[23] = vecs[i].r23;
         t = $sformatf("v%0d", i);
         run_check(t, vecs[i].c, scan_n, done_n, frz);
         check({t, "_scan_edge"}, 64'(scan_n), 64'(vecs[i].exp_scan));
         check({t, "_done_edge"}, 64'(done_n), 64'(vecs[i].exp_done));
         check({t, "_freeze_cycles"}, 64'(frz), 64'd8);
         check({t, "_busy_at_done"}, 64'(busy), 64'd0);
         check({t, "_pass"}, 64'(pass), 64'(vecs[i].exp_pass));
         check({t, "_fail_count"}, 64'(fail_count), 64'(vecs[i].exp_fc));
         check({t, "_ff_idx"}, 64'(first_fail_idx), 64'(vecs[i].exp_ffidx));
         check({t, "_ff_data"}, 64'(first_fail_data), 64'(vecs[i].exp_ffdata));
         check({t, "_cycle_held"}, 64'(cycle_count), 64'(vecs[i].exp_cyc));
         tick();
         check({t, "_done_held"}, 64'(done), 64'd1);
      end

      // Reset on the third SCAN cycle, after one mismatch has been recorded.
      rf_default();
      rf[19] = 32'd77;
      check_cycle = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_seen = 0;
      for (int n = 0; n < 50; n++) begin
         if (freeze) break;
         tick();
         n_seen++;
      end
      check("rstscan_reached_scan", 64'(freeze), 64'd1);
      tick();
      tick();
      check("rstscan_fail_before_rst", 64'(fail_count), 64'd1);
      check("rstscan_raddr_3rd", 64'(rf_raddr), 64'd21);
      rst = 1'b1;
      tick();
      check_reset_outputs("rstscan");
      rst = 1'b0;
      run_check("empty", 32'd2, scan_n, done_n, frz);
      check("empty_done_edge", 64'(done_n), 64'd10);
      check("empty_pass", 64'(pass), 64'd1);
      check("empty_fail_count", 64'(fail_count), 64'd0);

      // start and tbl_we during RUN must be ignored.
      rf_default();
      load_table();
      check_cycle = 32'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("busyin_cyc_before", 64'(cycle_count), 64'd4);
      check_cycle = 32'd3;
      start = 1'b1;
      tbl_idx = 3'd0; tbl_valid = 1'b1; tbl_addr = 5'd19; tbl_data = 32'd999;
      tbl_we = 1'b1;
      tick();
      start = 1'b0;
      tbl_we = 1'b0;
      check("busyin_cyc_after", 64'(cycle_count), 64'd5);
      check("busyin_busy", 64'(busy), 64'd1);
      done_n = -1;
      for (int n = 5; n <= 400; n++) begin
         tick();
         if (done) begin
            done_n = n;
            break;
         end
      end
      check("busyin_done_edge", 64'(done_n), 64'd28);
      check("busyin_pass", 64'(pass), 64'd1);
      check("busyin_fail_count", 64'(fail_count), 64'd0);
      check("busyin_cycle_held", 64'(cycle_count), 64'd20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_check_monitor.md
# reg_check_monitor

Synthesizable self-check monitor for the pipelined MIPS core. It counts clock cycles from a start pulse and, at a programmable checkpoint cycle, freezes the pipeline. It then scans up to NUM_CHECKS register-file entries through a dedicated read port, compares each against a loaded expected value, and reports pass/fail with first-failure detail. It replaces fixed-cycle, fixed-register simulation checks with a reusable, parametrised block that can sit beside `Top` on silicon or in any bench.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register-file address width
- NUM_CHECKS, 8, expected-table depth (≥1)
- CYCLE_W, 32, cycle counter / checkpoint width

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- check_cycle  in  CYCLE_W  checkpoint cycle, latched on accepted start
- tbl_we  in  1  expected-table write strobe; ignored while busy
- tbl_idx  in  $clog2(NUM_CHECKS)  table entry index
- tbl_valid  in  1  entry enable; 0 = skip entry during scan
- tbl_addr  in  ADDR_W  register address for entry
- tbl_data  in  DATA_W  expected value for entry
- rf_raddr  out  ADDR_W  register-file read address
- rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
- freeze  out  1  high in SCAN; pipeline must hold state
- busy  out  1  high in RUN or SCAN
- done  out  1  high in DONE
- pass  out  1  valid when done: fail_count == 0
- cycle_count  out  CYCLE_W  current cycle number
- fail_count  out  $clog2(NUM_CHECKS+1)  mismatching valid entries
- first_fail_idx  out  $clog2(NUM_CHECKS)  index of first mismatch
- first_fail_data  out  DATA_W  rf_rdata observed at first mismatch

## Operation
- States: IDLE, RUN, SCAN, DONE.
- IDLE/DONE + start: latch check_cycle; cycle_count←1; clear fail_count, first_fail_*, scan index. Go to RUN.
- RUN: when cycle_count == latched check_cycle, or latched check_cycle ≤ 1, go to SCAN on that edge. Otherwise cycle_count increments.
- SCAN: scan index i runs from 0 to NUM_CHECKS−1, one entry per cycle.
  - rf_raddr = tbl_addr[i].
  - If valid[i] and rf_rdata ≠ tbl_data[i] at the edge: fail_count increments. On the first such mismatch, first_fail_idx←i and first_fail_data←rf_rdata.
  - Invalid entries consume a cycle and are never counted.
  - After i = NUM_CHECKS−1, go to DONE.
- DONE: hold all results until start or rst. A start in DONE re-arms.
- Table writes are accepted in IDLE and DONE, land on the edge, and take effect for the next run.
- start while busy: ignored.
- rst at any time, including mid-SCAN: state←IDLE and all table valid bits cleared. All outputs return to reset values on the next edge.
- Reset values: rf_raddr 0, freeze 0, busy 0, done 0, pass 0, cycle_count 0, fail_count 0, first_fail_idx 0, first_fail_data 0.
- cycle_count does not wrap, because RUN exits at check_cycle. Checkpoint values ≥ 2^CYCLE_W−1 are legal and simply run long.

## Timing
- Start sampled at edge E0 → busy=1 and cycle_count=1 after E0.
- For check_cycle=C≥1: SCAN is entered after edge E(C). freeze is high for exactly NUM_CHECKS cycles.
- done and pass rise after edge E(C+NUM_CHECKS). busy falls on the same edge.
- Compare-to-result latency: 0 cycles (registered at the scan edge).
- freeze is a registered state decode and is glitch-free.

## Structure
- Package reg_check_pkg holds the state enum, the state encoding, and the localparam helper for index width.
- Sub-module reg_check_table: NUM_CHECKS-entry register array of {valid, addr, data}. It has one write port and one combinational read port. valid bits clear on rst; addr and data are not reset.
- Top-level reg_check_monitor holds the FSM, counters and compare logic.

## Test plan
- Load entries 0–5 with addr 19–24 and expected 15,10,3,2,10,11, valid; start with C=12 against a register-file model holding those values. Required: done after edge 12+8, pass=1, fail_count=0, freeze high exactly 8 cycles.
- Same run with reg 21 = 7. Required: pass=0, fail_count=1, first_fail_idx=2, first_fail_data=7.
- Two mismatches, at entries 1 and 4. Required: fail_count=2, first_fail_idx=1. Entries 6–7 invalid with mismatching data are not counted.
- C=0 and C=1. Required: SCAN entered after E1, done after E(1+NUM_CHECKS).
- Assert rst on the 3rd SCAN cycle. Required: next edge gives IDLE with all outputs at reset values; a following start with an empty table gives pass=1.
- start pulses and tbl_we pulses during RUN. Required: both ignored; the table is unchanged and cycle_count keeps incrementing.
